// File: rtl/mips_alu_pkg.sv
// Shared op-code and state encodings for the multi-cycle MIPS execute ALU.
package mips_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd6,
    OP_SLT  = 4'd7,
    OP_MULU = 4'd8,
    OP_DIVU = 4'd9,
    OP_MUL  = 4'd10,
    OP_DIV  = 4'd11,
    OP_NOR  = 4'd12,
    OP_XOR  = 4'd13
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_state_e;

  function automatic logic is_muldiv(input alu_op_e op);
    return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_divide(input alu_op_e op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mips_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per step.
// ALU_SIGNED_MULDIV_EN adds magnitude conversion and a final sign fix-up.
module mips_muldiv_iter
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             is_div,
`ifdef ALU_SIGNED_MULDIV_EN
  input  logic             sgn,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] hi_c,
  output logic [WIDTH-1:0] lo_c
);

  logic [WIDTH-1:0] acc_q, mq_q, opd_q;
  logic [WIDTH-1:0] acc_n, mq_n;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, trial;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q;

`ifdef ALU_SIGNED_MULDIV_EN
  logic               neg_lo_q, neg_hi_q;
  logic [2*WIDTH-1:0] prod_neg;

  assign a_mag    = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag    = (sgn && b[WIDTH-1]) ? -b : b;
  assign prod_neg = -{acc_n, mq_n};
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // One iteration: mul shifts {acc,mq} right after a conditional add,
  // div shifts {rem,quot} left and keeps the trial subtract when it fits.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, opd_q};
    trial = {acc_q, mq_q[WIDTH-1]} - {1'b0, opd_q};
    acc_n = acc_q;
    mq_n  = mq_q;
    if (div_q) begin
      if (!trial[WIDTH]) begin
        acc_n = trial[WIDTH-1:0];
        mq_n  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
        mq_n  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end else if (mq_q[0]) begin
      acc_n = sum[WIDTH:1];
      mq_n  = {sum[0], mq_q[WIDTH-1:1]};
    end else begin
      acc_n = {1'b0, acc_q[WIDTH-1:1]};
      mq_n  = {acc_q[0], mq_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    hi_c = acc_n;
    lo_c = mq_n;
`ifdef ALU_SIGNED_MULDIV_EN
    if (div_q) begin
      if (neg_lo_q) lo_c = -mq_n;
      if (neg_hi_q) hi_c = -acc_n;
    end else if (neg_lo_q) begin
      {hi_c, lo_c} = prod_neg;
    end
`endif
  end

  assign done_c = step && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      mq_q  <= '0;
      opd_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (start) begin
      acc_q <= '0;
      mq_q  <= a_mag;
      opd_q <= b_mag;
      cnt_q <= '0;
      div_q <= is_div;
    end else if (step) begin
      acc_q <= acc_n;
      mq_q  <= mq_n;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef ALU_SIGNED_MULDIV_EN
  // Quotient/product sign is the XOR of operand signs; remainder follows dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else if (start) begin
      neg_lo_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi_q <= sgn && is_div && a[WIDTH-1];
    end
  end
`endif

endmodule

// File: rtl/mips_alu_mc.sv
// Multi-cycle MIPS execute ALU: handshake, single-cycle datapath, result registers.
// Signed MUL/DIV when ALU_SIGNED_MULDIV_EN is defined, otherwise unsigned.
module mips_alu_mc
  import mips_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             zero,
  output logic             ovf,
  output logic             dz
);

  alu_state_e       state_q, state_d;
  alu_op_e          op;
  logic             accept, div_zero, md_start, md_done_c;
  logic [WIDTH-1:0] sum, diff, sc_lo, sc_hi, md_hi_c, md_lo_c;
  logic             sc_ovf, sc_dz;

  assign op        = alu_op_e'(ctl);
  assign in_ready  = (state_q == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign div_zero  = is_divide(op) && (b == '0);
  assign md_start  = accept && is_muldiv(op) && !div_zero;
  assign zero      = (out_lo == '0);
  assign sum       = a + b;
  assign diff      = a - b;

  // Single-cycle results, including divide-by-zero and undefined codes.
  always_comb begin
    sc_lo  = '0;
    sc_hi  = '0;
    sc_ovf = 1'b0;
    sc_dz  = 1'b0;
    case (op)
      OP_AND: sc_lo = a & b;
      OP_OR:  sc_lo = a | b;
      OP_NOR: sc_lo = ~(a | b);
      OP_XOR: sc_lo = a ^ b;
      OP_ADD: begin
        sc_lo  = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_lo  = diff;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: sc_lo = WIDTH'($signed(a) < $signed(b));
      OP_DIVU, OP_DIV: begin
        sc_lo = '1;
        sc_hi = a;
        sc_dz = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (md_start) state_d = ST_BUSY;
      ST_BUSY: if (md_done_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  mips_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .step   (state_q == ST_BUSY),
    .is_div (is_divide(op)),
`ifdef ALU_SIGNED_MULDIV_EN
    .sgn    ((op == OP_MUL) || (op == OP_DIV)),
`endif
    .a      (a),
    .b      (b),
    .done_c (md_done_c),
    .hi_c   (md_hi_c),
    .lo_c   (md_lo_c)
  );

  // Result registers: a single-cycle accept and an engine finish never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_lo    <= '0;
      out_hi    <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else if (accept && !md_start) begin
      out_valid <= 1'b1;
      out_lo    <= sc_lo;
      out_hi    <= sc_hi;
      ovf       <= sc_ovf;
      dz        <= sc_dz;
    end else if (md_done_c) begin
      out_valid <= 1'b1;
      out_lo    <= md_lo_c;
      out_hi    <= md_hi_c;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mips_alu_mc.md
# mips_alu_mc

Multi-cycle, parametrised MIPS execute-stage ALU with valid/ready handshakes on both sides. Single-cycle ops (ADD/SUB/AND/OR/NOR/XOR/SLT) complete in one cycle. MUL and DIV run on an iterative shift-add and restoring-divide engine that produces a full HI/LO result pair. It sits between the decode/issue stage and the writeback mux, and stalls issue through `in_ready` while a long operation is in flight.

## Interface
- `WIDTH`, default 32: operand and result width; must be at least 4.
- `CNT_W`, default $clog2(WIDTH)+1: width of the iteration counter.
- `clk`  in  1  Rising-edge clock.
- `rst_n`  in  1  Reset: asynchronous, active-low.
- `in_valid`  in  1  Operation request.
- `in_ready`  out  1  Block accepts a request this cycle.
- `ctl`  in  4  Op code: AND=0, OR=1, ADD=2, SUB=6, SLT=7, MULU=8, DIVU=9, MUL=10, DIV=11, NOR=12, XOR=13.
- `a`, `b`  in  WIDTH  Operands.
- `out_valid`  out  1  Result registers hold an unconsumed result.
- `out_ready`  in  1  Consumer takes the result.
- `out_lo`  out  WIDTH  Main result, or product low half, or quotient.
- `out_hi`  out  WIDTH  Product high half or remainder; 0 for single-cycle ops.
- `zero`  out  1  `out_lo == 0`.
- `ovf`  out  1  Signed overflow for ADD/SUB; 0 for every other op.
- `dz`  out  1  Divide by zero.

## Operation
- States:
  - IDLE: waiting for a request.
  - BUSY: engine iterating; counter runs 0..WIDTH-1.
- Handshake:
  - `in_ready = (state==IDLE) && (!out_valid || out_ready)`.
  - A transfer occurs when `in_valid && in_ready`.
- Single-cycle ops: the result registers load on the accept edge, and `out_valid` sets.
- MUL/DIV accept: latch operands, clear the counter, go to BUSY. Each BUSY edge performs one iteration. On the WIDTH-th iteration the engine:
  - loads `out_hi`/`out_lo`;
  - sets `out_valid`;
  - returns to IDLE.
- DIV/DIVU with `b==0`: no BUSY phase. Single-cycle result: `out_lo` = all ones, `out_hi = a`, `dz=1`.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - `ovf` follows the signed-overflow rule.
  - SLT is a signed compare and returns 1 or 0 in bit 0.
  - NOR is `~(a|b)`.
- Undefined `ctl` codes: accepted as single-cycle; `out_lo=out_hi=0`, `zero=1`, `ovf=dz=0`.
- Output hold: while `out_valid && !out_ready`, all outputs stay stable and `in_ready=0`.
- `out_valid` clears on the edge where `out_ready` is high, unless a new single-cycle accept on the same edge reloads it.
- Reset (asserted at any time, including mid-BUSY):
  - the operation aborts;
  - state goes to IDLE and the counter clears;
  - all outputs and result registers go to 0;
  - `in_ready` is 1 from the first edge after deassertion.

## Timing
- Single-cycle ops: latency 1. Accept at edge N gives `out_valid` visible after edge N.
- MUL/MULU/DIV/DIVU: latency WIDTH. Accept at edge N gives `out_valid` after edge N+WIDTH, and `in_ready=0` throughout.
- Divide by zero: latency 1.
- Throughput: one single-cycle op per clock with `out_ready` held high. A back-to-back accept and consume on the same edge is legal.
- `zero` is combinational from the `out_lo` register.

## Configuration
- `ALU_SIGNED_MULDIV_EN` defined:
  - MUL and DIV are signed. Operands are converted to magnitudes on accept, with a sign fix-up on the final iteration.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - MULU and DIVU are unsigned.
- `ALU_SIGNED_MULDIV_EN` undefined:
  - MUL and DIV are unsigned, identical to MULU and DIVU.
  - No sign logic is instantiated.

## Structure
- Package `mips_alu_pkg` holds:
  - the op-code enum `alu_op_e` (4-bit), with one constant per code listed above;
  - the state enum `alu_state_e`.
- Sub-module `mips_muldiv_iter` holds:
  - the iterative multiply/restoring-divide datapath: the WIDTH-bit accumulator/remainder, the shifting multiplier/quotient register, and the counter;
  - the optional sign handling.
- The top level holds the handshake, the single-cycle datapath and the result registers.

## Test plan
1. ADD a=0x7FFFFFFF, b=1 -> after 1 cycle `out_lo=0x80000000`, `ovf=1`, `zero=0`.
2. MULU a=0xFFFFFFFF, b=2 -> `in_ready=0` for 32 cycles, then `out_hi=0x00000001`, `out_lo=0xFFFFFFFE`.
3. DIVU a=100, b=7 -> after 32 cycles `out_lo=14`, `out_hi=2`. With the macro, DIV a=-7, b=2 -> `out_lo=0xFFFFFFFD`, `out_hi=0xFFFFFFFF`.
4. DIV a=5, b=0 -> after 1 cycle `out_lo=0xFFFFFFFF`, `out_hi=5`, `dz=1`.
5. SUB a=3, b=5 with `out_ready=0` for 5 cycles -> `out_lo=0xFFFFFFFE` held stable and `in_ready=0`. Raise `out_ready` -> result consumed, and the next op is accepted on the same edge.
6. Assert `rst_n=0` on cycle 10 of a MULU -> all outputs 0 and state IDLE. After release, AND a=0xF0, b=0x3C -> `out_lo=0x30` after 1 cycle.
